// File: rtl/regs_pkg.sv
// rtl/regs_pkg.sv - shared constants and helpers for the x0..x31 register file
package regs_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_W   = 32;
  localparam int ADDR_W  = $clog2(REG_NUM);

  localparam logic [REG_W-1:0]  ZERO_WORD = '0;
  localparam logic [ADDR_W-1:0] ZERO_REG  = '0;

  typedef logic [REG_NUM-1:0][REG_W-1:0] reg_array_t;

  // x0 is hardwired, so a write only takes effect when it targets x1..x31
  function automatic logic write_commits(input logic wen, input logic [ADDR_W-1:0] waddr);
    return wen && (waddr != ZERO_REG);
  endfunction

endpackage

// File: rtl/regs_if.sv
// rtl/regs_if.sv - execute/decode facing bus of the register file; optional debug read port under REGS_DBG_PORT_EN
interface regs_if #(
  parameter int CNT_W = 32
);
  import regs_pkg::*;

  logic              reg_wen_i;
  logic [ADDR_W-1:0] reg_waddr_i;
  logic [REG_W-1:0]  reg_wdata_i;
  logic [ADDR_W-1:0] reg1_raddr_i;
  logic [ADDR_W-1:0] reg2_raddr_i;
  logic [REG_W-1:0]  reg1_rdata_o;
  logic [REG_W-1:0]  reg2_rdata_o;
  logic [CNT_W-1:0]  wr_cnt_o;
`ifdef REGS_DBG_PORT_EN
  logic [ADDR_W-1:0] dbg_raddr_i;
  logic [REG_W-1:0]  dbg_rdata_o;
`endif

  modport master (
`ifdef REGS_DBG_PORT_EN
    output dbg_raddr_i,
    input  dbg_rdata_o,
`endif
    output reg_wen_i,
    output reg_waddr_i,
    output reg_wdata_i,
    output reg1_raddr_i,
    output reg2_raddr_i,
    input  reg1_rdata_o,
    input  reg2_rdata_o,
    input  wr_cnt_o
  );

  modport slave (
`ifdef REGS_DBG_PORT_EN
    input  dbg_raddr_i,
    output dbg_rdata_o,
`endif
    input  reg_wen_i,
    input  reg_waddr_i,
    input  reg_wdata_i,
    input  reg1_raddr_i,
    input  reg2_raddr_i,
    output reg1_rdata_o,
    output reg2_rdata_o,
    output wr_cnt_o
  );

endinterface

// File: rtl/regs_rd_port.sv
// rtl/regs_rd_port.sv - one combinational read port: x0, same-cycle write forward, then storage
module regs_rd_port
  import regs_pkg::*;
(
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]  wdata,
  input  reg_array_t        regs_q,
  output logic [REG_W-1:0]  rdata
);

  always_comb begin
    rdata = ZERO_WORD;
    if (!rst_n || raddr == ZERO_REG) begin
      rdata = ZERO_WORD;
    end else if (wen && raddr == waddr) begin
      rdata = wdata;
    end else begin
      rdata = regs_q[raddr];
    end
  end

endmodule

// File: rtl/regs.sv
// rtl/regs.sv - integer register file x0..x31 with forwarding and retired-write counter; REGS_DBG_PORT_EN adds a third read port
module regs
  import regs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  regs_if.slave bus
);

  reg_array_t       regs_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic             commit;

  assign commit = write_commits(bus.reg_wen_i, bus.reg_waddr_i);

  // Entry 0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q   <= '0;
      wr_cnt_q <= '0;
    end else if (commit) begin
      regs_q[bus.reg_waddr_i] <= bus.reg_wdata_i;
      wr_cnt_q                <= wr_cnt_q + CNT_W'(1);
    end
  end

  assign bus.wr_cnt_o = wr_cnt_q;

  regs_rd_port u_rd1 (
    .rst_n  (rst_n),
    .raddr  (bus.reg1_raddr_i),
    .wen    (bus.reg_wen_i),
    .waddr  (bus.reg_waddr_i),
    .wdata  (bus.reg_wdata_i),
    .regs_q (regs_q),
    .rdata  (bus.reg1_rdata_o)
  );

  regs_rd_port u_rd2 (
    .rst_n  (rst_n),
    .raddr  (bus.reg2_raddr_i),
    .wen    (bus.reg_wen_i),
    .waddr  (bus.reg_waddr_i),
    .wdata  (bus.reg_wdata_i),
    .regs_q (regs_q),
    .rdata  (bus.reg2_rdata_o)
  );

`ifdef REGS_DBG_PORT_EN
  regs_rd_port u_rd_dbg (
    .rst_n  (rst_n),
    .raddr  (bus.dbg_raddr_i),
    .wen    (bus.reg_wen_i),
    .waddr  (bus.reg_waddr_i),
    .wdata  (bus.reg_wdata_i),
    .regs_q (regs_q),
    .rdata  (bus.dbg_rdata_o)
  );
`endif

endmodule

// File: tb/tb_regs.sv
// tb/tb_regs.sv - self-checking bench for regs (counter width 4 to exercise wrap)
module tb_regs;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  regs_if #(.CNT_W(CNT_W)) bus ();

  regs #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [32];
  int          model_cnt;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    model_cnt = 0;
  endtask

  // Expected read: x0 is zero, a write in flight is visible, otherwise the stored value
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (bus.reg_wen_i && a == bus.reg_waddr_i) return bus.reg_wdata_i;
    return model_mem[a];
  endfunction

  task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.reg_wen_i    = wen;
    bus.reg_waddr_i  = wa;
    bus.reg_wdata_i  = wd;
    bus.reg1_raddr_i = r1;
    bus.reg2_raddr_i = r2;
  endtask

  // Advance one clock, updating the model with whatever the edge commits
  task automatic step();
    logic        do_wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    do_wr = rst_n && bus.reg_wen_i && bus.reg_waddr_i != 5'd0;
    wa = bus.reg_waddr_i;
    wd = bus.reg_wdata_i;
    @(posedge clk);
    if (do_wr) begin
      model_mem[wa] = wd;
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
    end
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1};
    vecs[2] = '{1'b1, 5'd0, 32'h1234, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1};
    vecs[3] = '{1'b1, 5'd7, 32'h55, 5'd7, 5'd7, 32'h55, 32'h55, 1};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 32'h55, 32'h0, 2};
    vecs[5] = '{1'b1, 5'd7, 32'hAA, 5'd7, 5'd5, 32'hAA, 32'hDEADBEEF, 2};
    vecs[6] = '{1'b0, 5'd3, 32'hFFFF, 5'd7, 5'd7, 32'hAA, 32'hAA, 3};

    model_reset();
`ifdef REGS_DBG_PORT_EN
    bus.dbg_raddr_i = 5'd0;
`endif
    // Reset held for 3 clocks with a write pending: ignored, outputs forced low
    drive(1'b1, 5'd5, 32'h1111, 5'd5, 5'd5);
    repeat (3) @(posedge clk);
    #2;
    check("rst_rd1", bus.reg1_rdata_o, 32'h0);
    check("rst_rd2", bus.reg2_rdata_o, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #2 rst_n = 1'b1;
    step();
    for (int a = 1; a < 32; a++) begin
      bus.reg1_raddr_i = 5'(a);
      bus.reg2_raddr_i = 5'(31 - a + 1);
      #1;
      check("post_rst_rd1", bus.reg1_rdata_o, 32'h0);
      check("post_rst_rd2", bus.reg2_rdata_o, 32'h0);
    end
    check("post_rst_cnt", 32'(bus.wr_cnt_o), 32'h0);

    // Table: checked just before each edge
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].r1, vecs[i].r2);
      #2;
      check($sformatf("vec%0d_rd1", i), bus.reg1_rdata_o, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), bus.reg2_rdata_o, vecs[i].exp2);
      check($sformatf("vec%0d_cnt", i), 32'(bus.wr_cnt_o), 32'(vecs[i].exp_cnt));
      step();
    end

    // Unknown address with write disabled must not disturb anything
    bus.reg_wen_i = 1'b0;
    bus.reg_waddr_i = 'x;
    bus.reg_wdata_i = 32'hBAD0BAD0;
    bus.reg1_raddr_i = 5'd7;
    bus.reg2_raddr_i = 5'd5;
    step();
    check("xaddr_cnt", 32'(bus.wr_cnt_o), 32'd3);
    check("xaddr_rd1", bus.reg1_rdata_o, 32'hAA);
    check("xaddr_rd2", bus.reg2_rdata_o, 32'hDEADBEEF);

    // Async reset between edges
    drive(1'b1, 5'd3, 32'h1, 5'd3, 5'd3);
    step();
    drive(1'b1, 5'd3, 32'h9, 5'd3, 5'd0);
    #2;
    check("fwd_before_rst", bus.reg1_rdata_o, 32'h9);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_rd1", bus.reg1_rdata_o, 32'h0);
    check("async_rst_cnt", 32'(bus.wr_cnt_o), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.reg_wen_i = 1'b0;
    bus.reg2_raddr_i = 5'd3;
    #1;
    check("x3_after_rst_rd1", bus.reg1_rdata_o, 32'h0);
    check("x3_after_rst_rd2", bus.reg2_rdata_o, 32'h0);
    check("cnt_after_rst", 32'(bus.wr_cnt_o), 32'h0);
    step();

    // 16 writes to x1 wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 5'd1, 32'(100 + i), 5'd1, 5'd2);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd0);
    #1;
    check("wrap_cnt", 32'(bus.wr_cnt_o), 32'h0);
    check("wrap_model_cnt", 32'(bus.wr_cnt_o), 32'(model_cnt));
    check("wrap_x1", bus.reg1_rdata_o, 32'd115);
`ifdef REGS_DBG_PORT_EN
    bus.dbg_raddr_i = 5'd1;
    #1;
    check("dbg_x1", bus.dbg_rdata_o, 32'd115);
`endif

    // Randomized traffic against the array model; narrow address range half the time
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, r1, r2;
      logic [4:0] mask;
      mask = ($urandom_range(1, 0) != 0) ? 5'h03 : 5'h1F;
      wa = 5'($urandom) & mask;
      r1 = 5'($urandom) & mask;
      r2 = 5'($urandom) & mask;
      drive(1'($urandom), wa, $urandom, r1, r2);
`ifdef REGS_DBG_PORT_EN
      bus.dbg_raddr_i = 5'($urandom) & mask;
`endif
      #2;
      check("rand_rd1", bus.reg1_rdata_o, model_read(r1));
      check("rand_rd2", bus.reg2_rdata_o, model_read(r2));
      check("rand_cnt", 32'(bus.wr_cnt_o), 32'(model_cnt));
`ifdef REGS_DBG_PORT_EN
      check("rand_dbg", bus.dbg_rdata_o, model_read(bus.dbg_raddr_i));
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
